mem_access_unit: RTL

- Load/store front end that sits directly upstream of the 256x32 data RAM and drives its clk/w_enable/data_addr/data_in/data_out port set.
- Accepts byte-addressed requests from the core (byte, halfword or word) over a valid/ready handshake.
- Performs read-modify-write for sub-word stores and extracts/extends sub-word loads.
- Returns one response per request over a second valid/ready handshake.

---
 rtl/mem_access_unit.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store front end for a 256x32 data RAM. It accepts byte-addressed
//   byte/half/word requests from the core and returns one response per
//   request. Sub-word stores are done as a read-modify-write. Sub-word loads
//   are extracted from their lane and then sign- or zero-extended.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_size, req_unsigned,
//   req_addr, req_wdata           request fields (byte address, right-justified data)
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_err          response payload
//   ram_w_enable, ram_addr,
//   ram_data_in, ram_data_out     RAM port set
//
// Parameters
//   ADDR_W  word-address width of the RAM
//   RD_LAT  RAM read latency, 0 (combinational) or 1 (registered)
//
// Configuration macro
//   MEM_ACCESS_MISALIGN_TRAP_EN  when defined, misaligned half/word requests
//   are answered with resp_err=1. When undefined, the low address bits are
//   forced aligned and the access goes ahead. A reserved size is an error
//   in both builds.
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_w_enable,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam logic c_trap = 1'b1;
`else
    localparam logic c_trap = 1'b0;
`endif

    // Final READ cycle: the counter reaches this value when RAM data is valid.
    localparam logic c_rd_last = (RD_LAT != 0);

    // Replace the addressed lane of old_word with the low bits of wdata.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] w;
        w = old_word;
        case (size)
            2'b00:   w[{off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   w[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    // Pick the addressed lane out of word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [1:0]          r_off;
    logic [31:0]         r_wdata;
    logic                r_rd_cnt;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic                r_wen;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [31:0]         r_ram_data_in;
    logic                w_req_misalign;
    logic [1:0]          w_req_off;
    logic                w_req_err;
    logic                w_rd_done;

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_rdata;
    assign resp_err     = r_err;
    assign ram_w_enable = r_wen;
    assign ram_addr     = r_ram_addr;
    assign ram_data_in  = r_ram_data_in;

    assign w_rd_done = (r_rd_cnt == c_rd_last);

    // Classify the incoming request and compute its effective lane offset.
    always_comb begin
        w_req_misalign = 1'b0;
        w_req_off      = req_addr[1:0];
        case (req_size)
            2'b01: begin
                w_req_misalign = req_addr[0];
                w_req_off      = {req_addr[1], 1'b0};
            end
            2'b10: begin
                w_req_misalign = (req_addr[1:0] != 2'b00);
                w_req_off      = 2'b00;
            end
            default: begin
                w_req_misalign = 1'b0;
                w_req_off      = req_addr[1:0];
            end
        endcase
        w_req_err = (req_size == 2'b11) | (c_trap & w_req_misalign);
    end

    // Next-state logic of the request FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_next = S_RESP;
                    end else if (req_we && (req_size == 2'b10)) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_READ: begin
                if (w_rd_done) begin
                    w_next = r_we ? S_WRITE : S_RESP;
                end else begin
                    w_next = S_READ;
                end
            end
            S_WRITE: w_next = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RESP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latches, RAM port registers and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we          <= 1'b0;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_off         <= 2'b00;
            r_wdata       <= 32'h0000_0000;
            r_rd_cnt      <= 1'b0;
            r_rdata       <= 32'h0000_0000;
            r_err         <= 1'b0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_wen         <= 1'b0;
            r_ram_addr    <= {ADDR_W{1'b0}};
            r_ram_data_in <= 32'h0000_0000;
        end else begin
            // Handshake outputs are decoded from the state being entered.
            r_req_ready  <= (w_next == S_IDLE);
            r_resp_valid <= (w_next == S_RESP);
            r_wen        <= (w_next == S_WRITE);
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= w_req_off;
                        r_wdata    <= req_wdata;
                        r_rd_cnt   <= 1'b0;
                        r_rdata    <= 32'h0000_0000;
                        r_err      <= w_req_err;
                        // Errored requests leave the RAM port untouched.
                        if (!w_req_err) begin
                            r_ram_addr    <= req_addr[ADDR_W+1:2];
                            r_ram_data_in <= req_wdata;
                        end
                    end
                end
                S_READ: begin
                    if (w_rd_done) begin
                        if (r_we) begin
                            r_ram_data_in <= lane_merge(ram_data_out, r_wdata, r_size, r_off);
                        end else begin
                            r_rdata <= lane_extract(ram_data_out, r_size, r_off, r_unsigned);
                        end
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_rdata <= 32'h0000_0000;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
